// File: rtl/demux_5ch_8bit.sv
// Five-channel valid/ready demultiplexer; each channel owns a 2-entry FIFO so
// in_ready depends only on sel and registered occupancy, never on out_ready.
module demux_5ch_8bit #(
    parameter int word_size = 8,
    parameter int depth     = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [word_size-1:0] data_in,
    input  logic [2:0]           sel,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [word_size-1:0] out_a,
    output logic [word_size-1:0] out_b,
    output logic [word_size-1:0] out_c,
    output logic [word_size-1:0] out_d,
    output logic [word_size-1:0] out_e,
    output logic [4:0]           out_valid,
    input  logic [4:0]           out_ready,
    output logic                 bad_sel,
    output logic [7:0]           bad_sel_count
);

    localparam logic [1:0] full_cnt = 2'(depth);

    logic [word_size-1:0] mem [5][2];
    logic [4:0]           wptr;
    logic [4:0]           rptr;
    logic [1:0]           cnt [5];
    logic                 legal;
    logic                 accept;
    logic [4:0]           push_ch;
    logic [4:0]           pop_ch;

    always_comb begin
        out_valid = '0;
        for (int unsigned i = 0; i < 5; i++) begin
            out_valid[i] = (cnt[i] != 2'd0);
        end
    end

    // Illegal selects are always accepted so the producer cannot stall on them.
    always_comb begin
        legal = (sel <= 3'd4);
        case (sel)
            3'd0:    in_ready = (cnt[0] != full_cnt);
            3'd1:    in_ready = (cnt[1] != full_cnt);
            3'd2:    in_ready = (cnt[2] != full_cnt);
            3'd3:    in_ready = (cnt[3] != full_cnt);
            3'd4:    in_ready = (cnt[4] != full_cnt);
            default: in_ready = 1'b1;
        endcase
        accept = in_valid && in_ready;
    end

    always_comb begin
        push_ch = '0;
        for (int unsigned i = 0; i < 5; i++) begin
            push_ch[i] = accept && legal && (sel == 3'(i));
        end
        pop_ch = out_valid & out_ready;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < 5; i++) begin
                mem[i][0] <= '0;
                mem[i][1] <= '0;
                cnt[i]    <= '0;
            end
            wptr          <= '0;
            rptr          <= '0;
            bad_sel       <= 1'b0;
            bad_sel_count <= '0;
        end else begin
            for (int unsigned i = 0; i < 5; i++) begin
                if (push_ch[i]) begin
                    mem[i][wptr[i]] <= data_in;
                    wptr[i]         <= ~wptr[i];
                end
                if (pop_ch[i]) begin
                    rptr[i] <= ~rptr[i];
                end
                case ({push_ch[i], pop_ch[i]})
                    2'b10:   cnt[i] <= cnt[i] + 2'd1;
                    2'b01:   cnt[i] <= cnt[i] - 2'd1;
                    default: cnt[i] <= cnt[i];
                endcase
            end
            bad_sel <= accept && !legal;
            if (accept && !legal && (bad_sel_count != '1)) begin
                bad_sel_count <= bad_sel_count + 8'd1;
            end
        end
    end

    assign out_a = mem[0][rptr[0]];
    assign out_b = mem[1][rptr[1]];
    assign out_c = mem[2][rptr[2]];
    assign out_d = mem[3][rptr[3]];
    assign out_e = mem[4][rptr[4]];

endmodule
